// File: rtl/slice_rd_sched_if.sv
// Bundle between the slice read scheduler and the slice buffers / output mux.
// The stall counter ports exist only when SLICE_RD_SCHED_STALL_CNT_EN is defined.
interface slice_rd_sched_if #(
  parameter int MAX_NBR_SLICES  = 2,
  parameter int MAX_SLICE_WIDTH = 2560
);
  localparam int SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
  localparam int SW_W  = $clog2(MAX_SLICE_WIDTH);

  logic                      flush;
  logic [9:0]                slices_per_line;
  logic [SW_W-1:0]           slice_width;
  logic [15:0]               frame_height;
  logic [MAX_NBR_SLICES-1:0] buf_empty;
  logic [MAX_NBR_SLICES-1:0] buf_sof;
  logic [MAX_NBR_SLICES-1:0] rd_en;
  logic [SEL_W-1:0]          rd_sel;
  logic [SEL_W-1:0]          mux_sel;
  logic                      mux_eol;
  logic                      mux_eof;
  logic                      sof_resync;

`ifdef SLICE_RD_SCHED_STALL_CNT_EN
  logic                      stall_cnt_clr;
  logic [15:0]               stall_cnt;

  modport master (
    input  flush, slices_per_line, slice_width, frame_height, buf_empty, buf_sof, stall_cnt_clr,
    output rd_en, rd_sel, mux_sel, mux_eol, mux_eof, sof_resync, stall_cnt
  );
  modport slave (
    output flush, slices_per_line, slice_width, frame_height, buf_empty, buf_sof, stall_cnt_clr,
    input  rd_en, rd_sel, mux_sel, mux_eol, mux_eof, sof_resync, stall_cnt
  );
`else
  modport master (
    input  flush, slices_per_line, slice_width, frame_height, buf_empty, buf_sof,
    output rd_en, rd_sel, mux_sel, mux_eol, mux_eof, sof_resync
  );
  modport slave (
    output flush, slices_per_line, slice_width, frame_height, buf_empty, buf_sof,
    input  rd_en, rd_sel, mux_sel, mux_eol, mux_eof, sof_resync
  );
`endif
endinterface

// File: rtl/slice_rd_sched.sv
// Read-side scheduler: walks slice buffers chunk by chunk per line, tags EOL/EOF, aligns mux controls.
// Optional stall counter enabled by defining SLICE_RD_SCHED_STALL_CNT_EN.
module slice_rd_sched #(
  parameter int MAX_NBR_SLICES  = 2,
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int RD_LATENCY      = 2
) (
  input  logic             clk_out_int,
  input  logic             rst,
  slice_rd_sched_if.master bus
);
  localparam int SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
  localparam int SW_W  = $clog2(MAX_SLICE_WIDTH);
  localparam int CNT_W = $clog2(MAX_SLICE_WIDTH >> 2);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] pix4_cnt_reg, pix4_cnt_next;
  logic [SEL_W-1:0] rd_sel_reg, rd_sel_next;
  logic [15:0]      line_cnt_reg, line_cnt_next;
  logic             sof_resync_reg;

  logic [SEL_W-1:0]      sel_pipe_reg [RD_LATENCY];
  logic [RD_LATENCY-1:0] eol_pipe_reg;
  logic [RD_LATENCY-1:0] eof_pipe_reg;

  logic [SW_W-1:0]  words_per_chunk;
  logic [CNT_W-1:0] chunk_last;
  logic [9:0]       spl_m1;
  logic [SEL_W-1:0] slice_last;
  logic [15:0]      frame_last;
  logic             empty_cur;
  logic             resync;
  logic             fire;
  logic             chunk_end;
  logic             line_end;
  logic             frame_end;
  logic             unused_sof;

  assign words_per_chunk = bus.slice_width >> 2;
  assign chunk_last      = (words_per_chunk == '0) ? '0 : CNT_W'(words_per_chunk - 1'b1);
  assign spl_m1          = (bus.slices_per_line == 10'd0) ? 10'd0 : bus.slices_per_line - 10'd1;
  // Clamp to the physical buffer count so rd_sel can never address a missing slice.
  assign slice_last      = (spl_m1 > 10'(MAX_NBR_SLICES - 1)) ? SEL_W'(MAX_NBR_SLICES - 1)
                                                               : SEL_W'(spl_m1);
  assign frame_last      = (bus.frame_height == 16'd0) ? 16'd0 : bus.frame_height - 16'd1;

  assign empty_cur = bus.buf_empty[rd_sel_reg];
  assign resync    = (state_reg == READ) && bus.buf_sof[0] &&
                     ((pix4_cnt_reg != '0) || (rd_sel_reg != '0) || (line_cnt_reg != 16'd0));
  assign fire      = (state_reg == READ) && !empty_cur && !resync;
  assign chunk_end = fire && (pix4_cnt_reg == chunk_last);
  assign line_end  = chunk_end && (rd_sel_reg == slice_last);
  assign frame_end = line_end && (line_cnt_reg == frame_last);
  assign unused_sof = ^bus.buf_sof;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_NBR_SLICES; gi++) begin : g_rd_en
      assign bus.rd_en[gi] = fire && (rd_sel_reg == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    pix4_cnt_next = pix4_cnt_reg;
    rd_sel_next   = rd_sel_reg;
    line_cnt_next = line_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.buf_sof[0]) begin
          state_next    = READ;
          pix4_cnt_next = '0;
          rd_sel_next   = '0;
          line_cnt_next = 16'd0;
        end
      end
      READ: begin
        if (resync) begin
          pix4_cnt_next = '0;
          rd_sel_next   = '0;
          line_cnt_next = 16'd0;
        end else if (fire) begin
          if (chunk_end) begin
            pix4_cnt_next = '0;
            if (line_end) begin
              rd_sel_next   = '0;
              line_cnt_next = line_cnt_reg + 16'd1;
              if (frame_end) begin
                state_next = DONE;
              end
            end else begin
              rd_sel_next = rd_sel_reg + 1'b1;
            end
          end else begin
            pix4_cnt_next = pix4_cnt_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_out_int) begin
    if (rst || bus.flush) begin
      state_reg      <= IDLE;
      pix4_cnt_reg   <= '0;
      rd_sel_reg     <= '0;
      line_cnt_reg   <= 16'd0;
      sof_resync_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pix4_cnt_reg   <= pix4_cnt_next;
      rd_sel_reg     <= rd_sel_next;
      line_cnt_reg   <= line_cnt_next;
      sof_resync_reg <= resync;
    end
  end

  // Tags travel with the slice index so the mux sees them together with the read data.
  always_ff @(posedge clk_out_int) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        sel_pipe_reg[i] <= '0;
      end
      eol_pipe_reg <= '0;
      eof_pipe_reg <= '0;
    end else begin
      sel_pipe_reg[0] <= rd_sel_reg;
      eol_pipe_reg[0] <= line_end;
      eof_pipe_reg[0] <= frame_end;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sel_pipe_reg[i] <= sel_pipe_reg[i-1];
        eol_pipe_reg[i] <= eol_pipe_reg[i-1];
        eof_pipe_reg[i] <= eof_pipe_reg[i-1];
      end
    end
  end

  assign bus.rd_sel     = rd_sel_reg;
  assign bus.mux_sel    = sel_pipe_reg[RD_LATENCY-1];
  assign bus.mux_eol    = eol_pipe_reg[RD_LATENCY-1];
  assign bus.mux_eof    = eof_pipe_reg[RD_LATENCY-1];
  assign bus.sof_resync = sof_resync_reg;

`ifdef SLICE_RD_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk_out_int) begin
    if (rst || bus.flush || bus.stall_cnt_clr) begin
      stall_cnt_reg <= 16'd0;
    end else if ((state_reg == READ) && empty_cur && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_slice_rd_sched.sv
// Bench for slice_rd_sched: three instances (read latency 1, 2, 4) share one stimulus and one frame-plan model.
module tb_slice_rd_sched;
  localparam int N   = 2;
  localparam int MSW = 2560;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, stall_cnt_clr;
  logic [9:0]  spl;
  logic [11:0] sw;
  logic [15:0] fh;
  logic [1:0]  buf_empty, buf_sof;

  logic [1:0]  rd_en_a   [3];
  logic [0:0]  rd_sel_a  [3];
  logic [0:0]  mux_sel_a [3];
  logic        mux_eol_a [3];
  logic        mux_eof_a [3];
  logic        resync_a  [3];
`ifdef SLICE_RD_SCHED_STALL_CNT_EN
  logic [15:0] stall_a   [3];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      slice_rd_sched_if #(.MAX_NBR_SLICES(N), .MAX_SLICE_WIDTH(MSW)) bus ();
      assign bus.flush           = flush;
      assign bus.slices_per_line = spl;
      assign bus.slice_width     = sw;
      assign bus.frame_height    = fh;
      assign bus.buf_empty       = buf_empty;
      assign bus.buf_sof         = buf_sof;
      slice_rd_sched #(
        .MAX_NBR_SLICES(N), .MAX_SLICE_WIDTH(MSW),
        .RD_LATENCY((gi == 0) ? 1 : (gi == 1) ? 2 : 4)
      ) u_dut (.clk_out_int(clk), .rst(rst), .bus(bus));
      assign rd_en_a[gi]   = bus.rd_en;
      assign rd_sel_a[gi]  = bus.rd_sel;
      assign mux_sel_a[gi] = bus.mux_sel;
      assign mux_eol_a[gi] = bus.mux_eol;
      assign mux_eof_a[gi] = bus.mux_eof;
      assign resync_a[gi]  = bus.sof_resync;
`ifdef SLICE_RD_SCHED_STALL_CNT_EN
      assign bus.stall_cnt_clr = stall_cnt_clr;
      assign stall_a[gi]       = bus.stall_cnt;
`endif
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: the frame is a flat list of reads; the DUT must walk it in order.
  typedef struct { int sel; bit eol; bit eof; } ent_t;
  ent_t plan[$];
  ent_t expq[3][$];
  int   lat[3] = '{1, 2, 4};
  int   phase;     // 0 idle, 1 reading, 2 frame finished
  int   idx;
  bit   exp_resync;
  int   exp_stall;

  int   rd_cyc[$];
  int   rd_sel_log[$];
  int   eol_cyc[3][$];
  int   eof_cyc[3][$];
  int   resync_cnt;

  function automatic void build_plan();
    int s_cnt = (spl == 0) ? 1 : int'(spl);
    int w_cnt = (sw / 4 == 0) ? 1 : int'(sw) / 4;
    int l_cnt = (fh == 0) ? 1 : int'(fh);
    plan.delete();
    for (int l = 0; l < l_cnt; l++)
      for (int s = 0; s < s_cnt; s++)
        for (int w = 0; w < w_cnt; w++) begin
          ent_t e;
          e.sel = s;
          e.eol = (s == s_cnt - 1) && (w == w_cnt - 1);
          e.eof = e.eol && (l == l_cnt - 1);
          plan.push_back(e);
        end
  endfunction

  function automatic void model_clear();
    ent_t z = '{0, 1'b0, 1'b0};
    phase = 0;
    idx = 0;
    exp_resync = 1'b0;
    for (int d = 0; d < 3; d++) begin
      expq[d].delete();
      for (int k = 0; k < lat[d]; k++) expq[d].push_back(z);
    end
  endfunction

  ent_t cur, nxt;
  bit   rs, fire_e;
  int   esel;
  logic [1:0] een;

  always @(negedge clk) begin
    if (rst) begin
      model_clear();
      exp_stall = 0;
    end else begin
      cur    = (phase == 1 && idx < plan.size()) ? plan[idx] : '{0, 1'b0, 1'b0};
      esel   = cur.sel;
      rs     = (phase == 1) && buf_sof[0] && (idx != 0);
      fire_e = (phase == 1) && !rs && !buf_empty[esel];
      een    = fire_e ? 2'(1 << esel) : 2'b00;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rd_en_L%0d", lat[d]), 32'(rd_en_a[d]), 32'(een));
        chk($sformatf("rd_sel_L%0d", lat[d]), 32'(rd_sel_a[d]), 32'(esel));
        chk($sformatf("mux_sel_L%0d", lat[d]), 32'(mux_sel_a[d]), 32'(expq[d][0].sel));
        chk($sformatf("mux_eol_L%0d", lat[d]), 32'(mux_eol_a[d]), 32'(expq[d][0].eol));
        chk($sformatf("mux_eof_L%0d", lat[d]), 32'(mux_eof_a[d]), 32'(expq[d][0].eof));
        chk($sformatf("sof_resync_L%0d", lat[d]), 32'(resync_a[d]), 32'(exp_resync));
`ifdef SLICE_RD_SCHED_STALL_CNT_EN
        chk($sformatf("stall_cnt_L%0d", lat[d]), 32'(stall_a[d]), 32'(exp_stall));
`endif
        if (mux_eol_a[d]) eol_cyc[d].push_back(cyc);
        if (mux_eof_a[d]) eof_cyc[d].push_back(cyc);
      end
      if (rd_en_a[1] != 2'b00) begin
        rd_cyc.push_back(cyc);
        rd_sel_log.push_back(int'(rd_sel_a[1]));
      end
      if (resync_a[1]) resync_cnt++;

      nxt = '{esel, fire_e && cur.eol, fire_e && cur.eof};
      for (int d = 0; d < 3; d++) begin
        void'(expq[d].pop_front());
        expq[d].push_back(nxt);
      end
      exp_resync = rs;
      if (flush || stall_cnt_clr) exp_stall = 0;
      else if (phase == 1 && buf_empty[esel] && exp_stall < 65535) exp_stall++;

      if (flush) begin
        model_clear();
      end else begin
        case (phase)
          0: if (buf_sof[0]) begin phase = 1; idx = 0; build_plan(); end
          1: begin
            if (rs) idx = 0;
            else if (fire_e) begin
              if (cur.eof) phase = 2;
              idx++;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    rd_sel_log.delete();
    for (int d = 0; d < 3; d++) begin
      eol_cyc[d].delete();
      eof_cyc[d].delete();
    end
    resync_cnt = 0;
  endtask

  task automatic start_frame();
    buf_sof = 2'b01;
    tick(1);
    buf_sof = 2'b00;
  endtask

  function automatic int rdc(input int i);
    return (rd_cyc.size() > i) ? rd_cyc[i] : -100;
  endfunction

  int basic_seq[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    rst = 1'b1; flush = 1'b0; stall_cnt_clr = 1'b0;
    spl = 10'd2; sw = 12'd8; fh = 16'd2; buf_empty = 2'b00; buf_sof = 2'b00;
    resync_cnt = 0;
    tick(3);
    rst = 1'b0;
    chk("reset_rd_en", 32'(rd_en_a[1]), 32'd0);
    chk("reset_rd_sel", 32'(rd_sel_a[1]), 32'd0);
    chk("reset_mux_eol", 32'(mux_eol_a[1]), 32'd0);
    chk("reset_sof_resync", 32'(resync_a[1]), 32'd0);
    tick(2);

    // basic frame: 2 slices x 2 words x 2 lines
    clear_logs();
    start_frame();
    tick(20);
    chk("basic_reads", rd_cyc.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("basic_sel%0d", i), (rd_sel_log.size() > i) ? rd_sel_log[i] : -1, basic_seq[i]);
    chk("basic_eol_cnt", eol_cyc[1].size(), 2);
    chk("basic_eol0_L2", (eol_cyc[1].size() > 0) ? eol_cyc[1][0] : -1, rdc(3) + 2);
    chk("basic_eol1_L2", (eol_cyc[1].size() > 1) ? eol_cyc[1][1] : -1, rdc(7) + 2);
    chk("basic_eof_cnt", eof_cyc[1].size(), 1);
    chk("basic_eof_L2", (eof_cyc[1].size() > 0) ? eof_cyc[1][0] : -1, rdc(7) + 2);
    chk("basic_eol0_L1", (eol_cyc[0].size() > 0) ? eol_cyc[0][0] : -1, rdc(3) + 1);
    chk("basic_eol0_L4", (eol_cyc[2].size() > 0) ? eol_cyc[2][0] : -1, rdc(3) + 4);

    // stall: slice 1 empty for 5 cycles at its first read
    clear_logs();
    stall_cnt_clr = 1'b1;
    tick(1);
    stall_cnt_clr = 1'b0;
    start_frame();
    tick(2);
    buf_empty = 2'b10;
    tick(5);
    buf_empty = 2'b00;
    tick(15);
    chk("stall_reads", rd_cyc.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("stall_sel%0d", i), (rd_sel_log.size() > i) ? rd_sel_log[i] : -1, basic_seq[i]);
    chk("stall_gap", rdc(2) - rdc(1), 6);
`ifdef SLICE_RD_SCHED_STALL_CNT_EN
    chk("stall_cnt_final", 32'(stall_a[1]), 32'd5);
`endif

    // single slice, one word per chunk, 3 lines
    spl = 10'd0; sw = 12'd4; fh = 16'd3;
    clear_logs();
    start_frame();
    tick(12);
    chk("single_reads", rd_cyc.size(), 3);
    chk("single_sel_sum", (rd_sel_log.size() == 3) ? rd_sel_log[0] + rd_sel_log[1] + rd_sel_log[2] : -1, 0);
    chk("single_eol_cnt", eol_cyc[1].size(), 3);
    chk("single_eof", (eof_cyc[1].size() > 0) ? eof_cyc[1][0] : -1, rdc(2) + 2);
    spl = 10'd2; sw = 12'd8; fh = 16'd2;

    // resync after 3 reads
    clear_logs();
    start_frame();
    tick(3);
    buf_sof = 2'b01;
    tick(1);
    buf_sof = 2'b00;
    tick(20);
    chk("resync_pulses", resync_cnt, 1);
    chk("resync_reads", rd_cyc.size(), 11);
    chk("resync_gap", rdc(3) - rdc(2), 2);
    chk("resync_eol_cnt", eol_cyc[1].size(), 2);
    chk("resync_eof", (eof_cyc[1].size() == 1) ? eof_cyc[1][0] : -1, rdc(10) + 2);

    // flush during 5th read
    clear_logs();
    start_frame();
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_rd_en", 32'(rd_en_a[1]), 32'd0);
    chk("flush_rd_sel", 32'(rd_sel_a[1]), 32'd0);
    chk("flush_mux_eol", 32'(mux_eol_a[1]), 32'd0);
    chk("flush_mux_eof", 32'(mux_eof_a[1]), 32'd0);
    tick(8);
    chk("flush_reads", rd_cyc.size(), 5);

    // reset during 5th read
    clear_logs();
    start_frame();
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_rd_en", 32'(rd_en_a[1]), 32'd0);
    chk("rst_rd_sel", 32'(rd_sel_a[1]), 32'd0);
    chk("rst_mux_eol", 32'(mux_eol_a[1]), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel_a[1]), 32'd0);
    tick(8);
    chk("rst_idle_reads", rd_cyc.size(), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
